// File: rtl/imm_pkg.sv
// Shared definitions for the immediate generator: format codes, pipeline
// occupancy states and parameter legality helpers.
package imm_pkg;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100,
        IMM_Z = 3'b101
    } immsrc_e;

    // Codes at or above this value are reserved (110, 111).
    localparam logic [2:0] IMM_RSVD_LO = 3'b110;

    // Occupancy encoded as {or_valid, sk_valid}; 01 cannot occur.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_FULL  = 2'b11
    } pipe_st_e;

    function automatic logic is_rsvd(input logic [2:0] src);
        return src >= IMM_RSVD_LO;
    endfunction

    function automatic bit xlen_ok(input int unsigned xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

endpackage

// File: rtl/imm_expand.sv
// Combinational immediate extractor: instruction word + format select to an
// XLEN-wide immediate. Stateless so any stage can reuse it.
module imm_expand
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  logic [2:0]      immsrc,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    logic [31:0] imm32;
    logic        sext;
    logic        unused_opc;

    // Opcode bits carry no immediate information.
    assign unused_opc = ^instr[6:0];

    always_comb begin
        imm32   = '0;
        sext    = 1'b1;
        illegal = is_rsvd(immsrc);
        case (immsrc)
            IMM_I: imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                            instr[11:8], 1'b0};
            IMM_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                            instr[30:21], 1'b0};
            IMM_U: imm32 = {instr[31:12], 12'h000};
            IMM_Z: begin
                imm32 = {27'd0, instr[19:15]};
                sext  = 1'b0;
            end
            default: imm32 = '0;
        endcase
        // U is sign-extended from bit 31 on RV64 just like the others.
        imm = sext ? XLEN'($signed(imm32)) : XLEN'(imm32);
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a 2-entry skid buffer so that in_ready
// comes straight from a flop and never depends on out_ready.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [2:0]      in_immsrc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic            out_illegal
);

    if (!xlen_ok(XLEN)) begin : g_bad_xlen
        $fatal(1, "imm_gen_pipe: XLEN must be 32 or 64");
    end

    logic [XLEN-1:0] exp_imm;
    logic            exp_ill;

    imm_expand #(.XLEN(XLEN)) u_expand (
        .instr   (in_instr),
        .immsrc  (in_immsrc),
        .imm     (exp_imm),
        .illegal (exp_ill)
    );

    pipe_st_e        state_q, state_d;
    logic            rdy_q, rdy_d;
    logic [XLEN-1:0] or_imm_q, or_imm_d;
    logic            or_ill_q, or_ill_d;
    logic [XLEN-1:0] sk_imm_q, sk_imm_d;
    logic            sk_ill_q, sk_ill_d;
    logic            acc, drn;

    assign out_valid   = state_q[1];
    assign out_imm     = or_imm_q;
    assign out_illegal = or_ill_q;
    assign in_ready    = rdy_q;

    assign acc = in_valid & rdy_q;
    assign drn = out_valid & out_ready;

    always_comb begin
        state_d  = state_q;
        or_imm_d = or_imm_q;
        or_ill_d = or_ill_q;
        sk_imm_d = sk_imm_q;
        sk_ill_d = sk_ill_q;
        case (state_q)
            ST_EMPTY: begin
                if (acc) begin
                    or_imm_d = exp_imm;
                    or_ill_d = exp_ill;
                    state_d  = ST_ONE;
                end
            end
            ST_ONE: begin
                if (acc && drn) begin
                    or_imm_d = exp_imm;
                    or_ill_d = exp_ill;
                end else if (acc) begin
                    sk_imm_d = exp_imm;
                    sk_ill_d = exp_ill;
                    state_d  = ST_FULL;
                end else if (drn) begin
                    state_d  = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so only a drain can happen.
                if (drn) begin
                    or_imm_d = sk_imm_q;
                    or_ill_d = sk_ill_q;
                    state_d  = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush) begin
            state_d = ST_EMPTY;
        end
        rdy_d = (state_d != ST_FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_EMPTY;
            rdy_q    <= 1'b1;
            or_imm_q <= '0;
            or_ill_q <= 1'b0;
            sk_imm_q <= '0;
            sk_ill_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rdy_q    <= rdy_d;
            or_imm_q <= or_imm_d;
            or_ill_q <= or_ill_d;
            sk_imm_q <= sk_imm_d;
            sk_ill_q <= sk_ill_d;
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances driven by the
// same stimulus, each checked against hand-computed immediates.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic [2:0]  in_immsrc = '0;
    logic        out_ready = 1'b1;

    logic        rdy32, vld32, ill32;
    logic [31:0] imm32;
    logic        rdy64, vld64, ill64;
    logic [63:0] imm64;

    int n_chk = 0;
    int n_err = 0;

    imm_gen_pipe #(.XLEN(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(rdy32), .in_instr(in_instr), .in_immsrc(in_immsrc),
        .out_valid(vld32), .out_ready(out_ready), .out_imm(imm32),
        .out_illegal(ill32)
    );

    imm_gen_pipe #(.XLEN(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(rdy64), .in_instr(in_instr), .in_immsrc(in_immsrc),
        .out_valid(vld64), .out_ready(out_ready), .out_imm(imm64),
        .out_illegal(ill64)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic [2:0] src);
        in_valid  = 1'b1;
        in_instr  = ins;
        in_immsrc = src;
    endtask

    initial begin
        // Reset
        #2 rst_n = 1'b0;
        #5;
        chk("rst_vld", {63'd0, vld32}, 64'd0);
        chk("rst_imm", {32'd0, imm32}, 64'd0);
        chk("rst_ill", {63'd0, ill32}, 64'd0);
        chk("rst_rdy", {63'd0, rdy32}, 64'd1);
        chk("rst_imm64", imm64, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // I-type
        drive(32'hFFF00093, 3'b000);
        step();
        in_valid = 1'b0;
        chk("i_vld", {63'd0, vld32}, 64'd1);
        chk("i_imm32", {32'd0, imm32}, 64'h0000_0000_FFFF_FFFF);
        chk("i_ill", {63'd0, ill32}, 64'd0);
        chk("i_imm64", imm64, 64'hFFFF_FFFF_FFFF_FFFF);
        step();
        chk("i_drain", {63'd0, vld32}, 64'd0);

        // B then J back to back
        drive(32'hFE000EE3, 3'b010);
        step();
        drive(32'hFF9FF06F, 3'b011);
        chk("b_vld", {63'd0, vld32}, 64'd1);
        chk("b_imm32", {32'd0, imm32}, 64'h0000_0000_FFFF_FFFC);
        step();
        in_valid = 1'b0;
        chk("j_vld", {63'd0, vld32}, 64'd1);
        chk("j_imm32", {32'd0, imm32}, 64'h0000_0000_FFFF_FFF8);
        step();
        chk("bj_drain", {63'd0, vld32}, 64'd0);

        // U and Z, checked on both widths
        drive(32'h123450B7, 3'b100);
        step();
        drive(32'h800000B7, 3'b100);
        chk("u1_imm64", imm64, 64'h0000_0000_1234_5000);
        chk("u1_imm32", {32'd0, imm32}, 64'h0000_0000_1234_5000);
        step();
        drive(32'h0001D073, 3'b101);
        chk("u2_imm64", imm64, 64'hFFFF_FFFF_8000_0000);
        chk("u2_imm32", {32'd0, imm32}, 64'h0000_0000_8000_0000);
        step();
        drive(32'hFFFFFFFF, 3'b111);
        chk("z_imm64", imm64, 64'h3);
        chk("z_ill", {63'd0, ill64}, 64'd0);
        step();
        in_valid = 1'b0;
        chk("rsv_imm32", {32'd0, imm32}, 64'd0);
        chk("rsv_ill32", {63'd0, ill32}, 64'd1);
        chk("rsv_imm64", imm64, 64'd0);
        chk("rsv_ill64", {63'd0, ill64}, 64'd1);
        step();

        // Back-pressure: two accepted, third waits
        out_ready = 1'b0;
        drive(32'h00100093, 3'b000);
        step();
        chk("bp1_rdy", {63'd0, rdy32}, 64'd1);
        chk("bp1_imm", {32'd0, imm32}, 64'd1);
        drive(32'h00200093, 3'b000);
        step();
        chk("bp2_rdy", {63'd0, rdy32}, 64'd0);
        chk("bp2_imm", {32'd0, imm32}, 64'd1);
        drive(32'h00300093, 3'b000);
        step();
        chk("bp3_rdy", {63'd0, rdy32}, 64'd0);
        chk("bp3_vld", {63'd0, vld32}, 64'd1);
        chk("bp3_hold", {32'd0, imm32}, 64'd1);
        out_ready = 1'b1;
        step();
        chk("bp4_imm", {32'd0, imm32}, 64'd2);
        chk("bp4_rdy", {63'd0, rdy32}, 64'd1);
        step();
        in_valid = 1'b0;
        chk("bp5_imm", {32'd0, imm32}, 64'd3);
        chk("bp5_vld", {63'd0, vld32}, 64'd1);
        step();
        chk("bp6_vld", {63'd0, vld32}, 64'd0);

        // Flush in FULL with a concurrent in_valid
        out_ready = 1'b0;
        drive(32'h00500093, 3'b000);
        step();
        drive(32'h00600093, 3'b000);
        step();
        chk("fl_full_rdy", {63'd0, rdy32}, 64'd0);
        drive(32'h00700093, 3'b000);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("fl_vld", {63'd0, vld32}, 64'd0);
        chk("fl_rdy", {63'd0, rdy32}, 64'd1);
        step();
        chk("fl_stale1", {63'd0, vld32}, 64'd0);
        step();
        chk("fl_stale2", {63'd0, vld32}, 64'd0);

        // Flush drops an accept in EMPTY
        drive(32'h00800093, 3'b000);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_drop", {63'd0, vld32}, 64'd0);

        // Async reset mid-cycle in ONE
        out_ready = 1'b0;
        drive(32'hFFF00093, 3'b111);
        step();
        in_valid = 1'b0;
        chk("ar_pre_vld", {63'd0, vld32}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_vld", {63'd0, vld32}, 64'd0);
        chk("ar_imm", {32'd0, imm32}, 64'd0);
        chk("ar_ill", {63'd0, ill32}, 64'd0);
        chk("ar_rdy", {63'd0, rdy32}, 64'd1);
        chk("ar_vld64", {63'd0, vld64}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
